// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned LineAddrLen = 2;
  localparam int unsigned SetAddrLen  = 3;
  localparam int unsigned TagAddrLen  = 6;
  localparam int unsigned MemAddrLen  = LineAddrLen + SetAddrLen + TagAddrLen;

  localparam int unsigned LINE_SIZE = 1 << LineAddrLen;
  localparam int unsigned SET_SIZE  = 1 << SetAddrLen;

  typedef enum logic [1:0] {
    StIdle,
    StSwapOut,
    StSwapIn,
    StSwapInOk
  } state_e;

  typedef struct packed {
    logic [TagAddrLen-1:0]  tag;
    logic [SetAddrLen-1:0]  set_idx;
    logic [LineAddrLen-1:0] word;
  } addr_fields_t;

  // Byte address -> {tag, set, word}; byte offset and bits above the memory range are dropped.
  function automatic addr_fields_t split_addr(input logic [31:0] addr);
    addr_fields_t f;
    f = addr[MemAddrLen+1:2];
    return f;
  endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Miss FSM: write-back of a dirty victim, pipelined line fill, memory-side muxing.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   hit,
  input  logic                   victim_dirty,
  input  logic [TagAddrLen-1:0]  req_tag,
  input  logic [SetAddrLen-1:0]  req_set,
  input  logic [TagAddrLen-1:0]  victim_tag,
  input  logic [31:0]            wb_word,
  output logic                   miss,
  output logic                   idle,
  output logic [LineAddrLen-1:0] word_idx,
  output logic                   fill_we,
  output logic [LineAddrLen-1:0] fill_word,
  output logic                   refill_done,
  output logic [SetAddrLen-1:0]  miss_set,
  output logic [TagAddrLen-1:0]  miss_tag,
  output logic [MemAddrLen-1:0]  mem_addr,
  output logic                   mem_wr_req,
  output logic [31:0]            mem_wr_data
);

  localparam logic [LineAddrLen-1:0] LastWord = LineAddrLen'(LINE_SIZE - 1);

  state_e                 state_q, state_d;
  logic [LineAddrLen-1:0] cnt_q, cnt_d;
  logic [SetAddrLen-1:0]  set_q, set_d;
  logic [TagAddrLen-1:0]  tag_q, tag_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      set_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    set_d       = set_q;
    tag_d       = tag_q;
    miss        = req;
    idle        = 1'b0;
    fill_we     = 1'b0;
    fill_word   = cnt_q - 1'b1;
    refill_done = 1'b0;
    mem_addr    = '0;
    mem_wr_req  = 1'b0;
    mem_wr_data = '0;
    unique case (state_q)
      StIdle: begin
        idle = 1'b1;
        miss = req & ~hit;
        if (req && !hit) begin
          set_d   = req_set;
          tag_d   = req_tag;
          cnt_d   = '0;
          state_d = victim_dirty ? StSwapOut : StSwapIn;
        end
      end
      StSwapOut: begin
        mem_wr_req  = 1'b1;
        mem_addr    = {victim_tag, set_q, cnt_q};
        mem_wr_data = wb_word;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LastWord) state_d = StSwapIn;
      end
      StSwapIn: begin
        // Read data lags the address by one cycle, so word k lands while word k+1 is addressed.
        mem_addr = {tag_q, set_q, cnt_q};
        fill_we  = (cnt_q != '0);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastWord) state_d = StSwapInOk;
      end
      StSwapInOk: begin
        fill_we     = 1'b1;
        fill_word   = LastWord;
        refill_done = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign word_idx = cnt_q;
  assign miss_set = set_q;
  assign miss_tag = tag_q;

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-back write-allocate data cache: arrays, hit path and counters.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = LineAddrLen,
  parameter int unsigned SET_ADDR_LEN  = SetAddrLen,
  parameter int unsigned TAG_ADDR_LEN  = TagAddrLen,
  parameter int unsigned MEM_ADDR_LEN  = MemAddrLen
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             addr,
  input  logic                    rd_req,
  input  logic                    wr_req,
  input  logic [31:0]             wr_data,
  output logic [31:0]             rd_data,
  output logic                    miss,
  output logic [MEM_ADDR_LEN-1:0] mem_addr,
  input  logic [31:0]             mem_rd_data,
  output logic                    mem_wr_req,
  output logic [31:0]             mem_wr_data,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int unsigned NumWords = 1 << LINE_ADDR_LEN;
  localparam int unsigned NumSets  = 1 << SET_ADDR_LEN;

  addr_fields_t fields;
  logic         unused_addr;

  assign fields      = split_addr(addr);
  assign unused_addr = ^{addr[31:MEM_ADDR_LEN+2], addr[1:0]};

  logic [31:0]             data_q [NumSets][NumWords];
  logic [TAG_ADDR_LEN-1:0] tag_q  [NumSets];
  logic [NumSets-1:0]      valid_q, dirty_q;
  logic [31:0]             rd_data_q, hit_cnt_q, miss_cnt_q;

  logic                     req, hit, victim_dirty, idle;
  logic                     fill_we, refill_done, wr_hit, rd_hit;
  logic [LINE_ADDR_LEN-1:0] word_idx, fill_word;
  logic [SET_ADDR_LEN-1:0]  miss_set;
  logic [TAG_ADDR_LEN-1:0]  miss_tag;

  assign req          = rd_req | wr_req;
  assign hit          = valid_q[fields.set_idx] && (tag_q[fields.set_idx] == fields.tag);
  assign victim_dirty = valid_q[fields.set_idx] & dirty_q[fields.set_idx];
  // Simultaneous rd_req and wr_req is resolved as a write.
  assign wr_hit       = idle & hit & wr_req;
  assign rd_hit       = idle & hit & rd_req & ~wr_req;

  dcache_ctrl u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .req_tag      (fields.tag),
    .req_set      (fields.set_idx),
    .victim_tag   (tag_q[miss_set]),
    .wb_word      (data_q[miss_set][word_idx]),
    .miss         (miss),
    .idle         (idle),
    .word_idx     (word_idx),
    .fill_we      (fill_we),
    .fill_word    (fill_word),
    .refill_done  (refill_done),
    .miss_set     (miss_set),
    .miss_tag     (miss_tag),
    .mem_addr     (mem_addr),
    .mem_wr_req   (mem_wr_req),
    .mem_wr_data  (mem_wr_data)
  );

  // Data and tags need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[miss_set][fill_word] <= mem_rd_data;
    end else if (wr_hit) begin
      data_q[fields.set_idx][fields.word] <= wr_data;
    end
    if (refill_done) tag_q[miss_set] <= miss_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      rd_data_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (refill_done) begin
        valid_q[miss_set] <= 1'b1;
        dirty_q[miss_set] <= 1'b0;
      end
      if (wr_hit) dirty_q[fields.set_idx] <= 1'b1;
      if (rd_hit) rd_data_q <= data_q[fields.set_idx][fields.word];
      if (idle && req) begin
        if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
        else     miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm against a 1-cycle registered word memory model.
module tb_dcache_dm;

  logic        clk, rst;
  logic [31:0] addr, wr_data, rd_data, mem_rd_data, mem_wr_data, hit_cnt, miss_cnt;
  logic        rd_req, wr_req, miss, mem_wr_req;
  logic [10:0] mem_addr;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [2048];
  logic [10:0] wlog_addr [$];
  logic [31:0] wlog_data [$];

  dcache_dm dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .miss        (miss),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_data (mem_wr_data),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_req === 1'b1) begin
      mem[mem_addr] <= mem_wr_data;
      wlog_addr.push_back(mem_addr);
      wlog_data.push_back(mem_wr_data);
    end
    mem_rd_data <= mem[mem_addr];
  end

  // Entered at posedge+1; returns at posedge+1 just after the access has been performed.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int cycles);
    rd_req = rd; wr_req = wr; addr = a; wr_data = d;
    cycles = 0;
    #1;
    while (miss === 1'b1 && cycles < 50) begin
      cycles++;
      @(posedge clk); #2;
    end
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (miss !== 1'b0) begin bad++; $display("FAIL reset_miss: got %b want 0", miss); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    total++; if (mem_wr_req !== 1'b0) begin bad++; $display("FAIL reset_mem_wr_req: got %b want 0", mem_wr_req); end
    total++; if (mem_addr !== 11'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    total++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      bad++; $display("FAIL reset_counters: got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_cold_read();
    int cyc;
    wlog_addr.delete(); wlog_data.delete();
    do_req(1'b1, 1'b0, 32'h4, 32'h0, cyc);
    total++; if (cyc != 6) begin bad++; $display("FAIL cold_latency: got %0d want 6", cyc); end
    total++; if (wlog_addr.size() != 0) begin bad++; $display("FAIL cold_no_writes: got %0d writes want 0", wlog_addr.size()); end
    total++; if (rd_data !== 32'h91) begin bad++; $display("FAIL cold_rd_data: got %h want 91", rd_data); end
    total++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd1) begin
      bad++; $display("FAIL cold_counters: got hit=%0d miss=%0d want 1/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_same_line_hit();
    int cyc;
    do_req(1'b1, 1'b0, 32'h8, 32'h0, cyc);
    total++; if (cyc != 0) begin bad++; $display("FAIL hit_latency: got %0d want 0", cyc); end
    total++; if (rd_data !== 32'h1a) begin bad++; $display("FAIL hit_rd_data: got %h want 1a", rd_data); end
    total++; if (hit_cnt !== 32'd2) begin bad++; $display("FAIL hit_cnt: got %0d want 2", hit_cnt); end
  endtask

  task automatic test_write_hit();
    int cyc;
    wlog_addr.delete(); wlog_data.delete();
    do_req(1'b0, 1'b1, 32'hC, 32'hDEAD, cyc);
    total++; if (cyc != 0) begin bad++; $display("FAIL wr_hit_latency: got %0d want 0", cyc); end
    total++; if (wlog_addr.size() != 0) begin bad++; $display("FAIL wr_hit_no_mem: got %0d writes want 0", wlog_addr.size()); end
    total++; if (rd_data !== 32'h1a) begin bad++; $display("FAIL wr_hit_rd_hold: got %h want 1a", rd_data); end
    total++; if (hit_cnt !== 32'd3) begin bad++; $display("FAIL wr_hit_cnt: got %0d want 3", hit_cnt); end
  endtask

  task automatic test_dirty_evict();
    int cyc;
    logic [31:0] exp_data [4];
    exp_data[0] = 32'h7; exp_data[1] = 32'h91; exp_data[2] = 32'h1a; exp_data[3] = 32'hDEAD;
    wlog_addr.delete(); wlog_data.delete();
    do_req(1'b1, 1'b0, 32'h80, 32'h0, cyc);
    total++; if (cyc != 10) begin bad++; $display("FAIL evict_latency: got %0d want 10", cyc); end
    total++; if (wlog_addr.size() != 4) begin bad++; $display("FAIL evict_nwrites: got %0d want 4", wlog_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= wlog_addr.size()) begin
        bad++; $display("FAIL evict_word%0d: got none want addr %0d data %h", i, i, exp_data[i]);
      end else if (wlog_addr[i] !== 11'(i) || wlog_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL evict_word%0d: got addr %0d data %h want addr %0d data %h",
                        i, wlog_addr[i], wlog_data[i], i, exp_data[i]);
      end
    end
    total++; if (rd_data !== 32'h6b) begin bad++; $display("FAIL evict_rd_data: got %h want 6b", rd_data); end
    total++; if (miss_cnt !== 32'd2 || hit_cnt !== 32'd4) begin
      bad++; $display("FAIL evict_counters: got hit=%0d miss=%0d want 4/2", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_writeback();
    int cyc;
    wlog_addr.delete(); wlog_data.delete();
    do_req(1'b1, 1'b0, 32'hC, 32'h0, cyc);
    total++; if (cyc != 6) begin bad++; $display("FAIL wb_latency: got %0d want 6", cyc); end
    total++; if (wlog_addr.size() != 0) begin bad++; $display("FAIL wb_clean_victim: got %0d writes want 0", wlog_addr.size()); end
    total++; if (rd_data !== 32'hDEAD) begin bad++; $display("FAIL wb_rd_data: got %h want dead", rd_data); end
    total++; if (mem[3] !== 32'hDEAD) begin bad++; $display("FAIL wb_mem3: got %h want dead", mem[3]); end
    total++; if (miss_cnt !== 32'd3 || hit_cnt !== 32'd5) begin
      bad++; $display("FAIL wb_counters: got hit=%0d miss=%0d want 5/3", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_rd_wr_both();
    int cyc;
    do_req(1'b1, 1'b1, 32'h8, 32'hBEEF, cyc);
    total++; if (cyc != 0) begin bad++; $display("FAIL both_latency: got %0d want 0", cyc); end
    total++; if (rd_data !== 32'hDEAD) begin bad++; $display("FAIL both_rd_hold: got %h want dead", rd_data); end
    do_req(1'b1, 1'b0, 32'h8, 32'h0, cyc);
    total++; if (rd_data !== 32'hBEEF) begin bad++; $display("FAIL both_written: got %h want beef", rd_data); end
    total++; if (hit_cnt !== 32'd7) begin bad++; $display("FAIL both_hit_cnt: got %0d want 7", hit_cnt); end
  endtask

  task automatic test_reset_mid_fill();
    int cyc;
    rd_req = 1'b1; addr = 32'h40;
    repeat (3) @(posedge clk);
    #1;
    total++; if (mem_addr !== 11'h012) begin bad++; $display("FAIL midfill_addr: got %h want 012", mem_addr); end
    rst = 1'b1; rd_req = 1'b0;
    #1;
    total++; if (miss !== 1'b0 || mem_wr_req !== 1'b0) begin
      bad++; $display("FAIL midfill_rst_ctl: got miss=%b wr=%b want 0/0", miss, mem_wr_req);
    end
    total++; if (mem_addr !== 11'h0 || mem_wr_data !== 32'h0) begin
      bad++; $display("FAIL midfill_rst_mem: got addr=%h data=%h want 0/0", mem_addr, mem_wr_data);
    end
    total++; if (rd_data !== 32'h0 || hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      bad++; $display("FAIL midfill_rst_regs: got rd=%h hit=%0d miss=%0d want 0/0/0", rd_data, hit_cnt, miss_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(1'b1, 1'b0, 32'h0, 32'h0, cyc);
    total++; if (cyc != 6) begin bad++; $display("FAIL midfill_reread_latency: got %0d want 6", cyc); end
    total++; if (rd_data !== 32'h7) begin bad++; $display("FAIL midfill_reread_data: got %h want 7", rd_data); end
    total++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd1) begin
      bad++; $display("FAIL midfill_counters: got hit=%0d miss=%0d want 1/1", hit_cnt, miss_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h1000 + 32'(i);
    mem[0] = 32'h7;   mem[1] = 32'h91;  mem[2] = 32'h1a;  mem[3] = 32'h3c;
    mem[32] = 32'h6b; mem[33] = 32'h22; mem[34] = 32'h5e; mem[35] = 32'h48;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_cold_read();
    test_same_line_hit();
    test_write_hit();
    test_dirty_evict();
    test_writeback();
    test_rd_wr_both();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
